// File: rtl/board_writer.sv
// Tic-tac-toe board writer: debounced key presses mark cells, then a one-cycle CHECK resolves win/draw/turn.
// Latency: press event at cycle E writes board at edge E+1; turn/winner/game_over follow at edge E+2.
// Backpressure: none; presses arriving during CHECK are dropped, refused presses pulse reject.
module board_writer #(
    parameter int TICK_DIV = 25000,
    parameter int DEB_LEN  = 3
) (
    input  logic        freq,
    input  logic        rst,
    input  logic [8:0]  key,
    input  logic        clr_key,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        move_done,
    output logic        reject
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    logic [CW-1:0]      cnt;
    logic               tick;
    logic [9:0]         raw_s1, raw_s2;
    logic [DEB_LEN-1:0] hist     [10];
    logic [DEB_LEN-1:0] hist_nxt [10];
    logic [9:0]         lvl;
    logic [9:0]         evt;
    logic [8:0]         cell_evt;
    logic               clr_evt;

    state_t      state, state_nxt;
    logic [17:0] board_nxt;
    logic        turn_nxt;
    logic [1:0]  winner_nxt;
    logic        move_done_nxt, reject_nxt;

    logic [3:0]  cell_idx;
    logic        single_evt;
    logic [1:0]  mark;
    logic [8:0]  own;
    logic        line_win;
    logic        full;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            hist_nxt[i] = (hist[i] << 1) | DEB_LEN'(raw_s2[i]);
        end
    end

    // Raw buttons are asynchronous to freq, so they pass a two-flop synchroniser before sampling.
    always_ff @(posedge freq or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            raw_s1 <= '0;
            raw_s2 <= '0;
            lvl    <= '0;
            evt    <= '0;
            for (int i = 0; i < 10; i++) begin
                hist[i] <= '0;
            end
        end else begin
            raw_s1 <= {clr_key, key};
            raw_s2 <= raw_s1;
            cnt    <= tick ? '0 : cnt + CW'(1);
            evt    <= '0;
            if (tick) begin
                for (int i = 0; i < 10; i++) begin
                    hist[i] <= hist_nxt[i];
                    if (&hist_nxt[i]) begin
                        lvl[i] <= 1'b1;
                        evt[i] <= ~lvl[i];
                    end else if (~|hist_nxt[i]) begin
                        lvl[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign cell_evt   = evt[8:0];
    assign clr_evt    = evt[9];
    assign single_evt = (cell_evt != 9'd0) && ((cell_evt & (cell_evt - 9'd1)) == 9'd0);

    always_comb begin
        cell_idx = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (cell_evt[i]) cell_idx = 4'(i);
        end
    end

    // In CHECK, turn still names the player who just moved.
    assign mark = {turn, ~turn};

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            own[i] = (board[2*i +: 2] == mark);
            if (board[2*i +: 2] == 2'd0) full = 1'b0;
        end
    end

    assign line_win = (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
                      (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
                      (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
                      (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);

    always_comb begin
        state_nxt     = state;
        board_nxt     = board;
        turn_nxt      = turn;
        winner_nxt    = winner;
        move_done_nxt = 1'b0;
        reject_nxt    = 1'b0;
        if (clr_evt) begin
            state_nxt  = PLAY;
            board_nxt  = '0;
            turn_nxt   = 1'b0;
            winner_nxt = 2'd0;
        end else begin
            case (state)
                PLAY: begin
                    if (cell_evt != 9'd0) begin
                        if (single_evt && (board[2*cell_idx +: 2] == 2'd0)) begin
                            board_nxt[2*cell_idx +: 2] = mark;
                            move_done_nxt              = 1'b1;
                            state_nxt                  = CHECK;
                        end else begin
                            reject_nxt = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (line_win) begin
                        winner_nxt = mark;
                        state_nxt  = OVER;
                    end else if (full) begin
                        winner_nxt = 2'd3;
                        state_nxt  = OVER;
                    end else begin
                        turn_nxt  = ~turn;
                        state_nxt = PLAY;
                    end
                end
                OVER: begin
                    if (cell_evt != 9'd0) reject_nxt = 1'b1;
                end
                default: state_nxt = PLAY;
            endcase
        end
    end

    always_ff @(posedge freq or negedge rst) begin
        if (!rst) begin
            state     <= PLAY;
            board     <= '0;
            turn      <= 1'b0;
            winner    <= 2'd0;
            move_done <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state     <= state_nxt;
            board     <= board_nxt;
            turn      <= turn_nxt;
            winner    <= winner_nxt;
            move_done <= move_done_nxt;
            reject    <= reject_nxt;
        end
    end

    assign game_over = (state == OVER);

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer with fast ticks (TICK_DIV=4, DEB_LEN=3).
module tb_board_writer;

    logic        freq = 1'b0;
    logic        rst  = 1'b0;
    logic [8:0]  key  = '0;
    logic        clr_key = 1'b0;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  winner;
    logic        game_over;
    logic        move_done;
    logic        reject;

    int checks   = 0;
    int failures = 0;
    int n_move   = 0;
    int n_rej    = 0;

    board_writer #(.TICK_DIV(4), .DEB_LEN(3)) dut (
        .freq      (freq),
        .rst       (rst),
        .key       (key),
        .clr_key   (clr_key),
        .board     (board),
        .turn      (turn),
        .winner    (winner),
        .game_over (game_over),
        .move_done (move_done),
        .reject    (reject)
    );

    always #5 freq = ~freq;

    always @(negedge freq) begin
        if (move_done) n_move++;
        if (reject)    n_rej++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge freq);
    endtask

    // k = 0..8 selects a cell, k = 9 the new-game button.
    task automatic press(input int k);
        if (k == 9) clr_key = 1'b1; else key[k] = 1'b1;
        wait_cyc(20);
        key = '0;
        clr_key = 1'b0;
        wait_cyc(20);
    endtask

    initial begin
        int mv0, rj0;
        bit seen;

        wait_cyc(3);
        check("rst_board", 32'(board), 32'h0);
        check("rst_turn", 32'(turn), 32'h0);
        check("rst_winner", 32'(winner), 32'h0);
        check("rst_over", 32'(game_over), 32'h0);
        check("rst_pulses", 32'({move_done, reject}), 32'h0);
        rst = 1'b1;
        wait_cyc(2);

        // Single press on centre with latency of turn update.
        key[4] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge freq);
            if (move_done) seen = 1;
        end
        check("c4_seen", 32'(seen), 32'h1);
        check("c4_board", 32'(board), 32'h00100);
        check("c4_turn_early", 32'(turn), 32'h0);
        @(negedge freq);
        check("c4_turn", 32'(turn), 32'h1);
        check("c4_over", 32'(game_over), 32'h0);
        key = '0;
        wait_cyc(20);
        check("c4_one_move", 32'(n_move), 32'd1);

        // Short glitch: only two high samples.
        mv0 = n_move;
        key[0] = 1'b1;
        wait_cyc(8);
        key = '0;
        wait_cyc(20);
        check("glitch_moves", 32'(n_move - mv0), 32'd0);
        check("glitch_board", 32'(board), 32'h00100);

        // Occupied cell refused.
        rj0 = n_rej;
        press(4);
        check("dup_reject", 32'(n_rej - rj0), 32'd1);
        check("dup_turn", 32'(turn), 32'h1);
        check("dup_board", 32'(board), 32'h00100);

        // Row win for player one.
        press(9);
        check("clr_board", 32'(board), 32'h0);
        check("clr_turn", 32'(turn), 32'h0);
        press(0); press(3); press(1); press(4); press(2);
        check("win_row", 32'(board[5:0]), 32'b010101);
        check("win_winner", 32'(winner), 32'd1);
        check("win_over", 32'(game_over), 32'h1);
        check("win_turn", 32'(turn), 32'h0);
        rj0 = n_rej;
        press(8);
        check("over_reject", 32'(n_rej - rj0), 32'd1);
        check("over_board", 32'(board), 32'h00295);
        check("over_winner", 32'(winner), 32'd1);

        // Full board, no line.
        press(9);
        mv0 = n_move;
        press(0); press(1); press(2); press(4); press(3);
        press(5); press(7); press(6); press(8);
        check("draw_moves", 32'(n_move - mv0), 32'd9);
        check("draw_board", 32'(board), 32'h16A59);
        check("draw_winner", 32'(winner), 32'd3);
        check("draw_over", 32'(game_over), 32'h1);

        // Clear wins over a simultaneous cell press.
        press(9);
        press(0);
        check("pre_clr_turn", 32'(turn), 32'h1);
        mv0 = n_move;
        rj0 = n_rej;
        key[2] = 1'b1;
        clr_key = 1'b1;
        wait_cyc(20);
        key = '0;
        clr_key = 1'b0;
        wait_cyc(20);
        check("clr_pri_board", 32'(board), 32'h0);
        check("clr_pri_turn", 32'(turn), 32'h0);
        check("clr_pri_winner", 32'(winner), 32'h0);
        check("clr_pri_pulses", 32'((n_move - mv0) + (n_rej - rj0)), 32'd0);

        // Reset during CHECK.
        press(0);
        key[5] = 1'b1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge freq);
            if (move_done) seen = 1;
        end
        check("chk_seen", 32'(seen), 32'h1);
        rst = 1'b0;
        key = '0;
        wait_cyc(3);
        rst = 1'b1;
        mv0 = n_move;
        rj0 = n_rej;
        wait_cyc(30);
        check("midrst_board", 32'(board), 32'h0);
        check("midrst_turn", 32'(turn), 32'h0);
        check("midrst_winner", 32'(winner), 32'h0);
        check("midrst_over", 32'(game_over), 32'h0);
        check("midrst_pulses", 32'((n_move - mv0) + (n_rej - rj0)), 32'd0);

        // Key held through reset release needs full debounce.
        rst = 1'b0;
        key[7] = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        mv0 = n_move;
        wait_cyc(10);
        check("held_early", 32'(n_move - mv0), 32'd0);
        wait_cyc(20);
        check("held_late", 32'(n_move - mv0), 32'd1);
        check("held_board", 32'(board), 32'h04000);
        key = '0;
        wait_cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
